// File: rtl/fir_cnn_seq_ctrl.sv
// fir_cnn_seq_ctrl: loads taps into the 3x3 FIR/CNN core, streams 3-row pixel columns, tags core results.
// Define FIR_CTRL_GRAY_EN to emit the grey average {g,g,g} of each result instead of raw RGB.
module fir_cnn_seq_ctrl #(
  parameter int COL = 320,
  parameter int ROW = 320,
  parameter int ADDR_W = 17,
  parameter int GAP_CYC = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              tap_wr,
  input  logic [3:0]        tap_idx,
  input  logic [7:0]        tap_in,
  output logic              busy,
  output logic              done,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  input  logic              rd_gnt,
  input  logic [23:0]       rd_data0,
  input  logic [23:0]       rd_data1,
  input  logic [23:0]       rd_data2,
  output logic              tc_set,
  output logic [23:0]       tc_data,
  output logic              valid_dmac,
  output logic [23:0]       input_data0,
  output logic [23:0]       input_data1,
  output logic [23:0]       input_data2,
  input  logic              valid_core,
  input  logic [23:0]       output_data,
  output logic              out_vld,
  output logic [ADDR_W-1:0] out_addr,
  output logic [23:0]       out_data
);
  localparam int CW = COL > 2 ? $clog2(COL) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(COL - 1);
  localparam logic [ADDR_W-1:0] A_COL = ADDR_W'(COL);
  localparam logic [ADDR_W-1:0] A_COL2 = ADDR_W'(2 * COL);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'((ROW - 2) * COL - 1);
  localparam logic [ADDR_W-1:0] N_OUT = ADDR_W'((ROW - 2) * (COL - 2));
  localparam logic [ADDR_W-1:0] N_LAST = ADDR_W'((ROW - 2) * (COL - 2) - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  typedef enum logic [2:0] {IDLE, TAPS, SETTLE, STREAM, GAP, DRAIN, DONE} state_t;
  state_t state;
  logic [7:0] tap [9];
  logic [3:0] tap_cnt;
  logic [7:0] wait_cnt;
  logic [CW-1:0] col;
  logic [ADDR_W-1:0] out_cnt;
  logic take, hit_last;
  logic [23:0] res;

  assign input_data0 = rd_data0;
  assign input_data1 = rd_data1;
  assign input_data2 = rd_data2;
  assign take = rd_req & rd_gnt;
  // a beat accepted this cycle that completes the frame lands together with done
  assign hit_last = out_cnt == N_OUT || (valid_core && out_cnt == N_LAST);

`ifdef FIR_CTRL_GRAY_EN
  logic [9:0] sum;
  logic [7:0] g;
  assign sum = 10'(output_data[23:16]) + 10'(output_data[15:8]) + 10'(output_data[7:0]);
  assign g = 8'(sum / 10'd3);
  assign res = {3{g}};
`else
  assign res = output_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      rd_req <= 1'b0;
      tc_set <= 1'b0;
      tc_data <= '0;
      valid_dmac <= 1'b0;
      rd_addr0 <= '0;
      rd_addr1 <= '0;
      rd_addr2 <= '0;
      out_vld <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      tap_cnt <= '0;
      wait_cnt <= '0;
      col <= '0;
      out_cnt <= '0;
      for (int i = 0; i < 9; i++) tap[i] <= '0;
    end else begin
      done <= 1'b0;
      valid_dmac <= take;
      out_vld <= busy && valid_core;
      if (busy && valid_core) begin
        out_data <= res;
        out_addr <= out_cnt;
        out_cnt <= out_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (tap_wr && tap_idx < 4'd9) tap[tap_idx] <= tap_in;
          if (start) begin
            state <= TAPS;
            busy <= 1'b1;
            tc_set <= 1'b1;
            tc_data <= {3{tap[0]}};
            tap_cnt <= '0;
            col <= '0;
            out_cnt <= '0;
            rd_addr0 <= '0;
            rd_addr1 <= A_COL;
            rd_addr2 <= A_COL2;
          end
        end
        TAPS: begin
          if (tap_cnt == 4'd8) begin
            state <= SETTLE;
            tc_set <= 1'b0;
            tc_data <= '0;
            wait_cnt <= '0;
          end else begin
            tap_cnt <= tap_cnt + 1'b1;
            tc_data <= {3{tap[tap_cnt + 4'd1]}};
          end
        end
        SETTLE: begin
          if (wait_cnt == SETTLE_LAST) begin
            state <= STREAM;
            rd_req <= 1'b1;
          end else wait_cnt <= wait_cnt + 1'b1;
        end
        STREAM: begin
          // raster order inside the band: one increment walks columns and wraps onto the next row
          if (take) begin
            rd_addr0 <= rd_addr0 + 1'b1;
            rd_addr1 <= rd_addr1 + 1'b1;
            rd_addr2 <= rd_addr2 + 1'b1;
            col <= col == C_LAST ? '0 : col + 1'b1;
            if (col == C_LAST) begin
              rd_req <= 1'b0;
              wait_cnt <= '0;
              state <= rd_addr0 == A_LAST ? DRAIN : GAP;
            end
          end
        end
        GAP: begin
          if (wait_cnt == GAP_LAST) begin
            state <= STREAM;
            rd_req <= 1'b1;
          end else wait_cnt <= wait_cnt + 1'b1;
        end
        DRAIN: begin
          if (hit_last) begin
            state <= DONE;
            done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_cnn_seq_ctrl.sv
// tb_fir_cnn_seq_ctrl: randomized grants and core results checked every cycle against a raster-order frame model.
module tb_fir_cnn_seq_ctrl;
  localparam int COL = 8, ROW = 6, AW = 17, GAP = 2, SETTLE = 2;
  localparam int NPIX = (ROW - 2) * COL;
  localparam int NOUT = (ROW - 2) * (COL - 2);
`ifdef FIR_CTRL_GRAY_EN
  localparam logic [23:0] GRAY_LIT = 24'h606060;
`else
  localparam logic [23:0] GRAY_LIT = 24'h306090;
`endif

  logic clk = 0, rst_n = 1, start = 0, tap_wr = 0;
  logic [3:0] tap_idx = 0;
  logic [7:0] tap_in = 0;
  logic busy, done, rd_req, tc_set, valid_dmac, out_vld;
  logic rd_gnt = 0, valid_core = 0;
  logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2, out_addr;
  logic [23:0] rd_data0 = 0, rd_data1 = 0, rd_data2 = 0, output_data = 0;
  logic [23:0] tc_data, input_data0, input_data1, input_data2, out_data;

  always #5 clk = ~clk;

  fir_cnn_seq_ctrl #(.COL(COL), .ROW(ROW), .ADDR_W(AW), .GAP_CYC(GAP), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tap_wr(tap_wr), .tap_idx(tap_idx), .tap_in(tap_in),
    .busy(busy), .done(done), .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2), .rd_gnt(rd_gnt), .rd_data0(rd_data0), .rd_data1(rd_data1),
    .rd_data2(rd_data2), .tc_set(tc_set), .tc_data(tc_data), .valid_dmac(valid_dmac),
    .input_data0(input_data0), .input_data1(input_data1), .input_data2(input_data2),
    .valid_core(valid_core), .output_data(output_data), .out_vld(out_vld), .out_addr(out_addr),
    .out_data(out_data)
  );

  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0, gi = 0, bc = 0, exp_cnt = 0, tap_left = 0, frames_done = 0;
  int last_tc = 0, row_end = 0, stall_left = 0, gnt_mode = 0, prev_a = 0, last_out_addr = 0;
  logic model_busy = 0, prev_take = 0, prev_req = 0, exp_vld = 0, first_beat = 0;
  logic [7:0] mtap [9];
  logic [23:0] tc_log [9];
  logic [23:0] exp_data = 0, first_out = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
  endtask

  function automatic logic [23:0] pix(input int a);
    return {8'(a), 8'(a * 7 + 3), 8'(a ^ 'h5A)};
  endfunction

  function automatic logic [23:0] core_out(input logic [23:0] d);
`ifdef FIR_CTRL_GRAY_EN
    int g;
    g = (int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0])) / 3;
    return {3{8'(g)}};
`else
    return d;
`endif
  endfunction

  always @(negedge clk) begin
    logic vc, gnt, take, busy_now, beat, done_exp;
    logic [23:0] od;
    cyc++;
    if (!rst_n) begin
      chk("rst_ctrl", {busy, done, rd_req, tc_set, valid_dmac, out_vld}, 0);
      chk("rst_tc_data", tc_data, 0);
      chk("rst_rd_addr", rd_addr0 | rd_addr1 | rd_addr2, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_out_data", out_data, 0);
      for (int i = 0; i < 9; i++) mtap[i] = 0;
      model_busy = 0; tap_left = 0; gi = 0; bc = 0; exp_cnt = 0;
      exp_vld = 0; prev_take = 0; prev_req = 0;
      rd_gnt = 0;
      valid_core = 1'($urandom_range(0, 1));
      output_data = $urandom;
    end else begin
      if (prev_take) begin
        rd_data0 = pix(prev_a); rd_data1 = pix(prev_a + COL); rd_data2 = pix(prev_a + 2 * COL);
      end else begin
        rd_data0 = $urandom; rd_data1 = $urandom; rd_data2 = $urandom;
      end
      #1;
      chk("busy", busy, model_busy);
      chk("valid_dmac", valid_dmac, prev_take);
      if (prev_take) begin
        chk("input_data0", input_data0, pix(prev_a));
        chk("input_data1", input_data1, pix(prev_a + COL));
        chk("input_data2", input_data2, pix(prev_a + 2 * COL));
      end
      if (rd_req && !prev_req) begin
        if (gi % COL != 0) chk("rd_req_midrow_rise", gi % COL, 0);
        else if (gi == 0) chk("settle_gap", cyc - last_tc, SETTLE + 1);
        else chk("row_gap", cyc - row_end, GAP + 1);
      end
      if (rd_req) begin
        chk("rd_req_allowed", gi < NPIX && tap_left == 0 && model_busy, 1);
        // pixel k of the band, fetched in raster order, lives at address k
        chk("rd_addr0", rd_addr0, gi);
        chk("rd_addr1", rd_addr1, gi + COL);
        chk("rd_addr2", rd_addr2, gi + 2 * COL);
      end
      chk("tc_set", tc_set, tap_left > 0);
      if (tap_left > 0) begin
        chk("tc_data", tc_data, {3{mtap[9 - tap_left]}});
        tc_log[9 - tap_left] = tc_data;
        tap_left--;
        last_tc = cyc;
      end else chk("tc_data_idle", tc_data, 0);
      chk("out_vld", out_vld, exp_vld);
      if (exp_vld) begin
        chk("out_data", out_data, exp_data);
        chk("out_addr", out_addr, exp_cnt);
        if (exp_cnt == 0) first_out = out_data;
        last_out_addr = out_addr;
        exp_cnt++;
      end
      done_exp = exp_vld && exp_cnt == NOUT;
      chk("done", done, done_exp);
      gnt = gnt_mode == 0 ? 1'b1 : 1'($urandom % 3 != 0);
      if (gnt_mode == 2 && rd_req && gi == 3 && stall_left > 0) begin
        gnt = 0;
        stall_left--;
      end
      rd_gnt = gnt;
      take = rd_req && gnt;
      prev_req = rd_req;
      beat = prev_take;
      if (take) begin
        prev_a = gi;
        if (gi % COL == COL - 1) row_end = cyc;
        gi++;
      end
      prev_take = take;
      busy_now = model_busy;
      vc = 0;
      od = $urandom;
      if (beat) begin
        if (bc >= 2) begin
          vc = 1;
          if (first_beat) begin od = 24'h306090; first_beat = 0; end
        end
        bc = bc == COL - 1 ? 0 : bc + 1;
      end
      if (!busy_now) vc = 1'($urandom % 4 == 0);
      valid_core = vc;
      output_data = od;
      exp_vld = vc && busy_now;
      exp_data = core_out(od);
      if (done_exp) begin
        model_busy = 0;
        frames_done++;
      end
      if (tap_wr && !busy_now && tap_idx < 9) mtap[tap_idx] = tap_in;
      if (start && !busy_now) begin
        model_busy = 1; tap_left = 9; gi = 0; bc = 0; exp_cnt = 0;
        first_beat = 1; stall_left = 5;
      end
    end
  end

  task automatic write_tap(input int i, input int v);
    @(posedge clk); #2 tap_wr = 1; tap_idx = 4'(i); tap_in = 8'(v);
    @(posedge clk); #2 tap_wr = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #2 start = 1;
    @(posedge clk); #2 start = 0;
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 3000 && frames_done < n; i++) @(posedge clk);
    chk("frame_done_timeout", frames_done, n);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int vals[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    for (int i = 0; i < 9; i++) write_tap(i, vals[i]);
    gnt_mode = 0;
    pulse_start();
    wait_frames(1);
    chk("lit_tc0", tc_log[0], 24'hFFFFFF);
    chk("lit_tc1", tc_log[1], 24'h000000);
    chk("lit_tc2", tc_log[2], 24'h010101);
    chk("lit_tc3", tc_log[3], 24'hFEFEFE);
    chk("lit_tc5", tc_log[5], 24'h020202);
    chk("lit_last_out_addr", last_out_addr, 23);
    chk("lit_first_out", first_out, GRAY_LIT);
    write_tap(12, 8'h55);
    gnt_mode = 2;
    pulse_start();
    repeat (20) @(posedge clk);
    pulse_start();
    write_tap(2, 8'h7F);
    wait_frames(2);
    gnt_mode = 1;
    pulse_start();
    wait_frames(3);
    chk("lit_tap2_kept", tc_log[2], 24'h010101);
    chk("lit_tap6_kept", tc_log[6], 24'hFFFFFF);
    pulse_start();
    for (int i = 0; i < 500 && gi < 11; i++) @(posedge clk);
    chk("reach_stream", gi >= 11, 1);
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    repeat (10) @(posedge clk);
    chk("no_done_after_reset", frames_done, 3);
    gnt_mode = 0;
    pulse_start();
    wait_frames(4);
    chk("lit_tc0_cleared", tc_log[0], 24'h000000);
    chk("lit_tc3_cleared", tc_log[3], 24'h000000);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/fir_cnn_seq_ctrl.md
Name: fir_cnn_seq_ctrl

Overview:
Sequencer for the 3x3 FIR/CNN filter core. It holds the 9 signed tap coefficients written by the host and, on start, loads them into the core (tc_set/tc_data). It then streams the image to the core as three vertically adjacent pixel rows, fetched through a grant-based memory read port. It collects the core's valid outputs, tags each with a linear output address, and pulses done when the whole image has been filtered.

Parameters:
COL, 320, image width in pixels
ROW, 320, image height in pixels
ADDR_W, 17, pixel address width; must satisfy 2^ADDR_W >= COL*ROW
GAP_CYC, 2, idle cycles with valid_dmac low between consecutive window rows
SETTLE_CYC, 2, idle cycles between end of tap load and first pixel

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle start pulse; honoured only in IDLE
tap_wr  in  1  host tap write strobe; honoured only in IDLE
tap_idx  in  4  tap index 0..8; writes with index >8 are dropped
tap_in  in  8  signed tap value
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of frame
rd_req  out  1  read request for one pixel column (3 rows)
rd_addr0  out  ADDR_W  address of top-row pixel
rd_addr1  out  ADDR_W  rd_addr0+COL
rd_addr2  out  ADDR_W  rd_addr0+2*COL
rd_gnt  in  1  memory accepts the current request
rd_data0/1/2  in  24  RGB pixel data, valid exactly 1 cycle after rd_gnt
tc_set  out  1  tap-load strobe to core
tc_data  out  24  {3{tap[i]}} during tap load; 0 otherwise
valid_dmac  out  1  pixel-valid to core
input_data0/1/2  out  24  rd_data0/1/2 passed through combinationally
valid_core  in  1  core output valid
output_data  in  24  core output pixel
out_vld  out  1  registered result valid
out_addr  out  ADDR_W  linear output index, 0..(ROW-2)*(COL-2)-1
out_data  out  24  registered result pixel

Behaviour:
- Reset: state=IDLE; all 9 taps=0; busy, done, rd_req, tc_set, valid_dmac and out_vld=0; tc_data, rd_addr*, out_addr and out_data=0; all counters=0. Reset mid-frame aborts immediately, with no done pulse.
- States: IDLE -> TAPS on start. TAPS: 9 cycles, tc_set=1, tc_data={3{tap[i]}} for i=0..8 in order. TAPS -> SETTLE: SETTLE_CYC cycles. SETTLE -> STREAM. STREAM -> GAP at the end of a row. GAP -> STREAM after GAP_CYC cycles. STREAM -> DRAIN after the last column of window row ROW-3 is granted. DRAIN -> DONE when the output count reaches (ROW-2)*(COL-2). DONE lasts 1 cycle with done=1, then -> IDLE.
- STREAM: window row r=0..ROW-3, column c=0..COL-1. rd_req=1 and rd_addr0=r*COL+c, generated by incrementing counters with no multiplier. The address advances only on the cycle rd_req and rd_gnt are both high; rd_req stays high with a stable address until granted.
- valid_dmac is rd_gnt registered: high the cycle after each grant, coincident with rd_data. A row ends on the grant of c=COL-1; rd_req drops the next cycle.
- Outputs: when busy and valid_core=1, the next cycle gives out_vld=1, out_data=output_data and out_addr=current count, then the count increments. valid_core in IDLE is ignored. Outputs may arrive during STREAM, GAP and DRAIN.
- Count reaching the target while a beat is in flight: the final out_vld and done both occur in that DONE cycle.
- start during busy: ignored. tap_wr during busy: ignored, taps unchanged.
- Taps retain their values across frames until rewritten.

Optional Feature:
FIR_CTRL_GRAY_EN: when defined, out_data = {g,g,g} with g = (R+G+B)/3, computed in 10-bit unsigned with truncating divide; latency is unchanged (still 1 cycle). When undefined, out_data = output_data unmodified.

Test Plan:
- Reset mid-STREAM (COL=8, ROW=6) -> next cycle all outputs 0 and busy=0; no done pulse; taps read back as 0 through the next frame's tc_data.
- Write taps 0..8 = -1,0,1,-2,0,2,-1,0,1, then start -> tc_set high exactly 9 cycles; tc_data sequence 0xFFFFFF, 0x000000, 0x010101, 0xFEFEFE, ...; valid_dmac=0 for 2 cycles afterwards.
- COL=8, ROW=6, rd_gnt tied 1 -> rd_addr0 takes values 0..7, then 8..15 after 2 gap cycles, and so on through 24..31. Core model emits 6 outputs per row -> 24 out_vld beats with out_addr 0..23, then a single done pulse; busy drops the cycle after.
- rd_gnt low for 5 cycles at c=3 -> rd_req held, rd_addr0 frozen at 3, valid_dmac low for those cycles; no pixel skipped or duplicated.
- start pulse while busy and tap_wr idx=2 while busy -> no restart, tap 2 unchanged in the next frame; tap_wr idx=12 in IDLE -> no tap modified.
- FIR_CTRL_GRAY_EN defined, output_data=0x30_60_90 -> out_data=0x606060. Undefined -> out_data=0x306090.
